// File: rtl/serial_reg_master_if.sv
// Parallel command/response bus between the on-chip controller and the
// serial register master. The controller holds the master modport and
// the serial_reg_master holds the slave modport.
interface serial_reg_master_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int REG_WIDTH  = 8
) ();
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_wr;
    logic [ADDR_WIDTH:0]   cmd_addr;
    logic [REG_WIDTH-1:0]  cmd_wdata;
    logic                  rsp_valid;
    logic                  rsp_err;
    logic [REG_WIDTH-1:0]  rsp_rdata;

    modport master (
        output cmd_valid, cmd_wr, cmd_addr, cmd_wdata,
        input  cmd_ready, rsp_valid, rsp_err, rsp_rdata
    );

    modport slave (
        input  cmd_valid, cmd_wr, cmd_addr, cmd_wdata,
        output cmd_ready, rsp_valid, rsp_err, rsp_rdata
    );
endinterface

// File: rtl/serial_reg_master.sv
// Bit-serial register-access master: turns parallel read/write commands
// into strobe/wr_en/din frames and collects the dout reply framed by rw_flag.
// Outputs are decoded from the registered state so they change only on clk.
module serial_reg_master #(
    parameter int ADDR_WIDTH = 4,
    parameter int REG_WIDTH  = 8,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    serial_reg_master_if.slave    bus,
    output logic                  strobe,
    output logic                  wr_en,
    output logic                  din,
    input  logic                  dout,
    input  logic                  rw_flag
);
    localparam int AW  = ADDR_WIDTH + 1;
    localparam int N   = REG_WIDTH + AW;
    localparam int BCW = $clog2(N + 1);
    localparam int TCW = $clog2(TIMEOUT + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_START   = 3'd1;
    localparam logic [2:0] S_SHIFT   = 3'd2;
    localparam logic [2:0] S_GUARD   = 3'd3;
    localparam logic [2:0] S_WAIT_RD = 3'd4;
    localparam logic [2:0] S_CAPTURE = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;

    logic [2:0]           state_q,   state_d;
    logic                 wr_q,      wr_d;
    logic [N-1:0]         shift_q,   shift_d;
    logic [REG_WIDTH-1:0] rdata_q,   rdata_d;
    logic                 err_q,     err_d;
    logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [TCW-1:0]       to_cnt_q,  to_cnt_d;

    // Last SHIFT bit index depends on frame direction (data+addr vs addr only).
    logic [BCW-1:0] shift_last;
    assign shift_last = wr_q ? BCW'(N - 1) : BCW'(AW - 1);

    // Next-state and datapath update for the transaction sequencer.
    always_comb begin
        state_d   = state_q;
        wr_d      = wr_q;
        shift_d   = shift_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        bit_cnt_d = bit_cnt_q;
        to_cnt_d  = to_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    wr_d      = bus.cmd_wr;
                    // Write frame is data LSB-first then address; the
                    // concatenation puts data in the low bits shifted out first.
                    shift_d   = bus.cmd_wr ? {bus.cmd_addr, bus.cmd_wdata}
                                           : N'(bus.cmd_addr);
                    rdata_d   = '0;
                    err_d     = 1'b0;
                    bit_cnt_d = '0;
                    state_d   = S_START;
                end
            end
            S_START: state_d = S_SHIFT;
            S_SHIFT: begin
                shift_d = shift_q >> 1;
                if (bit_cnt_q == shift_last) begin
                    bit_cnt_d = '0;
                    to_cnt_d  = '0;
                    state_d   = wr_q ? S_GUARD : S_WAIT_RD;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            S_GUARD: begin
                if (bit_cnt_q == BCW'(1)) state_d = S_DONE;
                else                      bit_cnt_d = bit_cnt_q + 1'b1;
            end
            S_WAIT_RD: begin
                if (rw_flag) begin
                    // Reply bits enter at the MSB; after REG_WIDTH shifts the
                    // first received bit sits at bit 0.
                    rdata_d   = {dout, rdata_q[REG_WIDTH-1:1]};
                    bit_cnt_d = BCW'(1);
                    state_d   = (REG_WIDTH == 1) ? S_DONE : S_CAPTURE;
                end else if (to_cnt_q == TCW'(TIMEOUT - 1)) begin
                    to_cnt_d = TCW'(TIMEOUT);
                    err_d    = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            S_CAPTURE: begin
                if (rw_flag) begin
                    rdata_d = {dout, rdata_q[REG_WIDTH-1:1]};
                    if (bit_cnt_q == BCW'(REG_WIDTH - 1)) state_d = S_DONE;
                    else                                  bit_cnt_d = bit_cnt_q + 1'b1;
                end else begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with synchronous abort on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            wr_q      <= 1'b0;
            shift_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            bit_cnt_q <= '0;
            to_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            wr_q      <= wr_d;
            shift_q   <= shift_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            bit_cnt_q <= bit_cnt_d;
            to_cnt_q  <= to_cnt_d;
        end
    end

    assign bus.cmd_ready = (state_q == S_IDLE);
    assign bus.rsp_valid = (state_q == S_DONE);
    assign bus.rsp_err   = (state_q == S_DONE) && err_q;
    assign bus.rsp_rdata = ((state_q == S_DONE) && !err_q) ? rdata_q : '0;

    assign strobe = (state_q == S_START);
    assign wr_en  = wr_q && ((state_q == S_START) || (state_q == S_SHIFT) ||
                             (state_q == S_GUARD));
    assign din    = (state_q == S_SHIFT) && shift_q[0];
endmodule

// File: tb/tb_serial_reg_master.sv
// Directed bench for serial_reg_master with a behavioural serial slave.
module tb_serial_reg_master;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic strobe, wr_en, din;
    logic dout = 1'b0;
    logic rw_flag = 1'b0;

    int tests_run    = 0;
    int tests_failed = 0;

    serial_reg_master_if #(.ADDR_WIDTH(4), .REG_WIDTH(8)) bus ();

    serial_reg_master #(.ADDR_WIDTH(4), .REG_WIDTH(8), .TIMEOUT(64)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .strobe  (strobe),
        .wr_en   (wr_en),
        .din     (din),
        .dout    (dout),
        .rw_flag (rw_flag)
    );

    always #5 clk = ~clk;

    // Behavioural slave: samples the link on falling edges, drives replies
    // on falling edges so the master sees half a cycle of setup.
    logic [7:0] mem [0:31];
    int reply_len   = 8;
    int reply_delay = 0;

    initial begin : slave_model
        logic        w;
        logic [12:0] frame;
        logic [4:0]  a;
        int          nbits;
        forever begin
            @(negedge clk);
            if (!rst && strobe) begin
                w     = wr_en;
                nbits = w ? 13 : 5;
                frame = '0;
                for (int i = 0; i < nbits; i++) begin
                    @(negedge clk);
                    frame[i] = din;
                end
                if (w) begin
                    @(negedge clk);
                    if (wr_en) mem[frame[12:8]] = frame[7:0];
                end else begin
                    a = frame[4:0];
                    repeat (reply_delay) @(negedge clk);
                    for (int i = 0; i < reply_len; i++) begin
                        @(negedge clk);
                        if (rst) break;
                        rw_flag = 1'b1;
                        dout    = mem[a][i];
                    end
                    if (!rst) @(negedge clk);
                    rw_flag = 1'b0;
                    dout    = 1'b0;
                end
            end
        end
    end

    // Drives one command and waits for its response; all callers start and
    // end on a falling edge. rcyc is the response cycle (acceptance = 0).
    task automatic run_cmd(input logic wr, input logic [4:0] a, input logic [7:0] d,
                           output int rcyc, output logic err, output logic [7:0] rd);
        int g = 0;
        while (!bus.cmd_ready && g < 200) begin @(negedge clk); g++; end
        bus.cmd_valid = 1'b1; bus.cmd_wr = wr; bus.cmd_addr = a; bus.cmd_wdata = d;
        @(negedge clk);
        bus.cmd_valid = 1'b0; bus.cmd_wr = ~wr; bus.cmd_addr = ~a; bus.cmd_wdata = ~d;
        rcyc = -1; err = 1'bx; rd = 'x;
        for (int k = 1; k < 200; k++) begin
            if (bus.rsp_valid) begin
                rcyc = k; err = bus.rsp_err; rd = bus.rsp_rdata;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.cmd_valid = 1'b0; bus.cmd_wr = 1'b0;
        bus.cmd_addr = '0; bus.cmd_wdata = '0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, strobe, wr_en, din} !== 13'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got rv=%b err=%b rd=%h st=%b we=%b din=%b, want all 0",
                     bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, strobe, wr_en, din);
        end
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (bus.cmd_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_ready: got %b want 1", bus.cmd_ready);
        end
        $display("[TB] reset done");
    endtask

    task automatic test_write();
        logic [12:0] exp_din = 13'b0001110100101;
        logic [4:0]  got, exp;
        bus.cmd_valid = 1'b1; bus.cmd_wr = 1'b1; bus.cmd_addr = 5'd3; bus.cmd_wdata = 8'hA5;
        @(negedge clk);
        bus.cmd_valid = 1'b0; bus.cmd_wr = 1'b0; bus.cmd_addr = 5'd7; bus.cmd_wdata = 8'hFF;
        for (int k = 1; k <= 18; k++) begin
            if (k > 1) @(negedge clk);
            got = {strobe, wr_en, din, bus.rsp_valid, bus.rsp_err};
            exp = {k == 1, k <= 16, (k >= 2 && k <= 14) ? exp_din[k-2] : 1'b0, k == 17, 1'b0};
            tests_run++;
            if (got !== exp) begin
                tests_failed++;
                $display("FAIL write_cycle%0d: got st/we/din/rv/err=%b want %b", k, got, exp);
            end
        end
        tests_run++;
        if (bus.cmd_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL write_ready_after: got %b want 1", bus.cmd_ready);
        end
        tests_run++;
        if (mem[3] !== 8'hA5) begin
            tests_failed++;
            $display("FAIL write_commit: slave reg3=%h want a5", mem[3]);
        end
        $display("[TB] write addr=3 data=a5 slave=%h", mem[3]);
    endtask

    task automatic test_read();
        logic [4:0] exp_din = 5'b01010;
        int rcyc = -1;
        logic err = 1'bx;
        logic [7:0] rd = 'x;
        mem[10] = 8'h3C; reply_len = 8; reply_delay = 0;
        bus.cmd_valid = 1'b1; bus.cmd_wr = 1'b0; bus.cmd_addr = 5'd10; bus.cmd_wdata = 8'h11;
        @(negedge clk);
        bus.cmd_valid = 1'b0; bus.cmd_wr = 1'b1; bus.cmd_addr = 5'd0;
        for (int k = 1; k < 100; k++) begin
            if (k > 1) @(negedge clk);
            if (k >= 2 && k <= 6) begin
                tests_run++;
                if ({din, wr_en} !== {exp_din[k-2], 1'b0}) begin
                    tests_failed++;
                    $display("FAIL read_addr_cycle%0d: got din=%b we=%b want din=%b we=0",
                             k, din, wr_en, exp_din[k-2]);
                end
            end
            if (bus.rsp_valid) begin rcyc = k; err = bus.rsp_err; rd = bus.rsp_rdata; break; end
        end
        tests_run++;
        if (rcyc !== 15 || err !== 1'b0 || rd !== 8'h3C) begin
            tests_failed++;
            $display("FAIL read_rsp: got cyc=%0d err=%b rd=%h want cyc=15 err=0 rd=3c", rcyc, err, rd);
        end
        $display("[TB] read addr=10 cyc=%0d err=%b rd=%h", rcyc, err, rd);
    endtask

    task automatic test_timeout();
        int rcyc; logic err; logic [7:0] rd;
        reply_len = 0;
        run_cmd(1'b0, 5'd4, 8'h00, rcyc, err, rd);
        tests_run++;
        if (rcyc !== 71 || err !== 1'b1 || rd !== 8'h00) begin
            tests_failed++;
            $display("FAIL timeout_rsp: got cyc=%0d err=%b rd=%h want cyc=71 err=1 rd=00", rcyc, err, rd);
        end
        @(negedge clk);
        tests_run++;
        if (bus.cmd_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL timeout_ready: got %b want 1", bus.cmd_ready);
        end
        reply_len = 8;
        $display("[TB] timeout read cyc=%0d err=%b rd=%h", rcyc, err, rd);
    endtask

    task automatic test_short_reply();
        int rcyc; logic err; logic [7:0] rd;
        mem[6] = 8'hFF; reply_len = 5; reply_delay = 1;
        run_cmd(1'b0, 5'd6, 8'h00, rcyc, err, rd);
        tests_run++;
        if (rcyc !== 14 || err !== 1'b1 || rd !== 8'h00) begin
            tests_failed++;
            $display("FAIL short_rsp: got cyc=%0d err=%b rd=%h want cyc=14 err=1 rd=00", rcyc, err, rd);
        end
        reply_len = 8; reply_delay = 0;
        @(negedge clk);
        $display("[TB] short reply cyc=%0d err=%b rd=%h", rcyc, err, rd);
    endtask

    task automatic test_back_to_back();
        int r1 = -1, r2 = -1, extra = 0;
        logic st19 = 1'b0, we19 = 1'b1, rdy18 = 1'b0;
        logic [7:0] rd2 = 'x;
        bus.cmd_valid = 1'b1; bus.cmd_wr = 1'b1; bus.cmd_addr = 5'd5; bus.cmd_wdata = 8'h5A;
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            if (k == 1) bus.cmd_wr = 1'b0;
            if (k >= 2 && k <= 18 && strobe) extra++;
            if (k == 18) rdy18 = bus.cmd_ready;
            if (k == 19) begin st19 = strobe; we19 = wr_en; bus.cmd_valid = 1'b0; end
            if (bus.rsp_valid && r1 < 0) r1 = k;
            else if (bus.rsp_valid && r2 < 0) begin r2 = k; rd2 = bus.rsp_rdata; end
        end
        tests_run++;
        if (r1 !== 17 || rdy18 !== 1'b1 || extra !== 0) begin
            tests_failed++;
            $display("FAIL b2b_first: got rsp=%0d ready18=%b strobes=%0d want 17,1,0", r1, rdy18, extra);
        end
        tests_run++;
        if (st19 !== 1'b1 || we19 !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_accept: got cycle19 strobe=%b we=%b want 1,0", st19, we19);
        end
        tests_run++;
        if (r2 !== 33 || rd2 !== 8'h5A) begin
            tests_failed++;
            $display("FAIL b2b_read: got cyc=%0d rd=%h want 33, 5a", r2, rd2);
        end
        $display("[TB] back-to-back rsp1=%0d rsp2=%0d rd=%h", r1, r2, rd2);
    endtask

    task automatic test_busy();
        int strobes = 0, rsps = 0, rcyc = -1, busy_ready = 0;
        bus.cmd_valid = 1'b1; bus.cmd_wr = 1'b1; bus.cmd_addr = 5'd9; bus.cmd_wdata = 8'h3C;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            if (k > 1) @(negedge clk);
            if (k >= 2 && strobe) strobes++;
            if (bus.rsp_valid) begin rsps++; rcyc = k; end
            bus.cmd_valid = 1'b0;
            if (k == 5 || k == 10) begin
                if (bus.cmd_ready) busy_ready++;
                bus.cmd_valid = 1'b1; bus.cmd_wr = 1'b0; bus.cmd_addr = 5'd1;
            end
        end
        bus.cmd_valid = 1'b0;
        tests_run++;
        if (strobes !== 0 || rsps !== 1 || rcyc !== 17 || busy_ready !== 0) begin
            tests_failed++;
            $display("FAIL busy_ignore: got strobes=%0d rsps=%0d rcyc=%0d ready=%0d want 0,1,17,0",
                     strobes, rsps, rcyc, busy_ready);
        end
        tests_run++;
        if (mem[9] !== 8'h3C) begin
            tests_failed++;
            $display("FAIL busy_commit: slave reg9=%h want 3c", mem[9]);
        end
        $display("[TB] busy pulses strobes=%0d rsps=%0d reg9=%h", strobes, rsps, mem[9]);
    endtask

    task automatic test_reset_mid_read();
        int rsps = 0, rcyc; logic err; logic [7:0] rd;
        mem[2] = 8'h96; reply_len = 8; reply_delay = 0;
        bus.cmd_valid = 1'b1; bus.cmd_wr = 1'b0; bus.cmd_addr = 5'd2;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (k > 1) @(negedge clk);
            if (bus.rsp_valid) rsps++;
            if (k == 10) rst = 1'b1;
            if (k == 11) begin
                tests_run++;
                if ({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, strobe, wr_en, din, bus.cmd_ready}
                    !== 14'd1) begin
                    tests_failed++;
                    $display("FAIL midreset_outputs: got rv=%b err=%b rd=%h st=%b we=%b din=%b rdy=%b",
                             bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, strobe, wr_en, din, bus.cmd_ready);
                end
            end
            if (k == 12) rst = 1'b0;
        end
        tests_run++;
        if (rsps !== 0) begin
            tests_failed++;
            $display("FAIL midreset_no_rsp: got %0d responses want 0", rsps);
        end
        run_cmd(1'b0, 5'd2, 8'h00, rcyc, err, rd);
        tests_run++;
        if (rcyc !== 15 || err !== 1'b0 || rd !== 8'h96) begin
            tests_failed++;
            $display("FAIL midreset_reread: got cyc=%0d err=%b rd=%h want 15,0,96", rcyc, err, rd);
        end
        @(negedge clk);
        $display("[TB] reset mid-read then reread rd=%h", rd);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 8'(i * 7);
        @(negedge clk);
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_short_reply();
        test_back_to_back();
        test_busy();
        test_reset_mid_read();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
